lcd_pic_overlay_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-image LCD pixel generator.
//  Per pixel it composes background, one ROM-backed image window and a row of
//  N_BTN switch-status buttons. Buttons flash on every switch edge.

---
 rtl/lcd_pic_overlay_pipe.sv | 168 ++++++++++++++++
 tb/tb_lcd_pic_overlay_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pic_overlay_pipe.sv
// rtl/lcd_pic_overlay_pipe.sv - pipelined pixel composer: background, ROM image window, flashing switch buttons
// Latency is ROM_LAT+2: classify, wait for ROM data, then compose the output pixel.
module lcd_pic_overlay_pipe #(
    parameter int          IMG_WIDTH    = 560,
    parameter int          IMG_HEIGHT   = 320,
    parameter int          ORIGIN_X     = 120,
    parameter int          ORIGIN_Y     = 80,
    parameter int          ADDR_W       = 18,
    parameter int          ROM_LAT      = 1,
    parameter int          N_BTN        = 4,
    parameter int          BTN_X0       = 120,
    parameter int          BTN_Y0       = 300,
    parameter int          BTN_W        = 140,
    parameter int          BTN_H        = 100,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] COL_ON       = 24'hBEBEBE,
    parameter logic [23:0] COL_OFF      = 24'hFF0000,
    parameter logic [23:0] COL_FLASH    = 24'hFFFF00,
    parameter logic [23:0] COL_BG       = 24'hFFFFFF
) (
    input  logic              clk_in,
    input  logic              sys_rst,
    input  logic [N_BTN-1:0]  sw,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [23:0]       pix_data,
    output logic              pix_data_valid
);
    localparam int          CLS_W    = 6;
    localparam logic [31:0] IMG_X_LO = 32'(ORIGIN_X);
    localparam logic [31:0] IMG_X_HI = 32'(ORIGIN_X + IMG_WIDTH);
    localparam logic [31:0] IMG_Y_LO = 32'(ORIGIN_Y);
    localparam logic [31:0] IMG_Y_HI = 32'(ORIGIN_Y + IMG_HEIGHT);
    localparam logic [31:0] BTN_Y_LO = 32'(BTN_Y0);
    localparam logic [31:0] BTN_Y_HI = 32'(BTN_Y0 + BTN_H);
    localparam logic [7:0]  FLASH_LD = 8'(FLASH_FRAMES);

    logic [31:0]       w_x;
    logic [31:0]       w_y;
    logic              w_in_img;
    logic              w_btn_row;
    logic              w_btn_hit;
    logic [2:0]        w_btn_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [CLS_W-1:0]  w_cls;
    logic [CLS_W-1:0]  r_cls [0:ROM_LAT];
    logic [ADDR_W-1:0] r_rom_addr;
    logic [N_BTN-1:0]  r_sw_m;
    logic [N_BTN-1:0]  r_sw_s;
    logic [N_BTN-1:0]  r_sw_h;
    logic [N_BTN-1:0]  w_sw_edge;
    logic              w_frame_start;
    logic [7:0]        r_flash_cnt [0:N_BTN-1];
    logic              w_o_valid;
    logic              w_o_img;
    logic              w_o_hit;
    logic [2:0]        w_o_idx;
    logic              w_o_flash;
    logic              w_o_sw;
    logic [23:0]       w_btn_col;
    logic [23:0]       w_pix;
    logic [23:0]       r_pix_data;
    logic              r_pix_valid;

    assign w_x       = {21'd0, pix_x};
    assign w_y       = {21'd0, pix_y};
    assign w_in_img  = (w_x >= IMG_X_LO) && (w_x < IMG_X_HI) &&
                       (w_y >= IMG_Y_LO) && (w_y < IMG_Y_HI);
    assign w_addr    = ADDR_W'((w_y - IMG_Y_LO) * 32'(IMG_WIDTH) + (w_x - IMG_X_LO));
    assign w_btn_row = (w_y >= BTN_Y_LO) && (w_y < BTN_Y_HI);

    always_comb begin
        w_btn_hit = 1'b0;
        w_btn_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_btn_row && (w_x >= 32'(BTN_X0 + i * BTN_W)) &&
                (w_x < 32'(BTN_X0 + (i + 1) * BTN_W))) begin
                w_btn_hit = 1'b1;
                w_btn_idx = 3'(i);
            end
        end
    end

    assign w_cls = {pix_valid, w_in_img, w_btn_hit, w_btn_idx};

    // Class bits ride a delay line so they meet rom_data in the output cycle.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_rom_addr <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_cls[k] <= '0;
            end
        end else begin
            r_rom_addr <= w_in_img ? w_addr : '0;
            r_cls[0]   <= w_cls;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_cls[k] <= r_cls[k-1];
            end
        end
    end

    assign w_sw_edge     = r_sw_s ^ r_sw_h;
    assign w_frame_start = pix_valid && (pix_x == 11'd0) && (pix_y == 11'd0);

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_sw_m <= '0;
            r_sw_s <= '0;
            r_sw_h <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_flash_cnt[i] <= 8'd0;
            end
        end else begin
            r_sw_m <= sw;
            r_sw_s <= r_sw_m;
            r_sw_h <= r_sw_s;
            // A reload on a switch edge takes precedence over the frame decrement.
            for (int i = 0; i < N_BTN; i++) begin
                if (w_sw_edge[i]) begin
                    r_flash_cnt[i] <= FLASH_LD;
                end else if (w_frame_start && (r_flash_cnt[i] != 8'd0)) begin
                    r_flash_cnt[i] <= r_flash_cnt[i] - 8'd1;
                end
            end
        end
    end

    assign {w_o_valid, w_o_img, w_o_hit, w_o_idx} = r_cls[ROM_LAT];

    always_comb begin
        w_o_flash = 1'b0;
        w_o_sw    = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_o_idx == 3'(i)) begin
                w_o_flash = (r_flash_cnt[i] != 8'd0);
                w_o_sw    = r_sw_s[i];
            end
        end
        w_btn_col = w_o_flash ? COL_FLASH : (w_o_sw ? COL_ON : COL_OFF);
        if (!w_o_valid) begin
            w_pix = 24'h0;
        end else if (w_o_hit) begin
            w_pix = w_btn_col;
        end else if (w_o_img) begin
            w_pix = rom_data;
        end else begin
            w_pix = COL_BG;
        end
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_pix_data  <= 24'h0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_data  <= w_pix;
            r_pix_valid <= w_o_valid;
        end
    end

    assign rom_addr       = r_rom_addr;
    assign pix_data       = r_pix_data;
    assign pix_data_valid = r_pix_valid;

endmodule

// File: tb/tb_lcd_pic_overlay_pipe.sv
// tb/tb_lcd_pic_overlay_pipe.sv - bench for lcd_pic_overlay_pipe with ROM_LAT=1 and ROM_LAT=3 instances
module tb_lcd_pic_overlay_pipe;
    localparam logic [23:0] COL_ON    = 24'hBEBEBE;
    localparam logic [23:0] COL_OFF   = 24'hFF0000;
    localparam logic [23:0] COL_FLASH = 24'hFFFF00;
    localparam logic [23:0] COL_BG    = 24'hFFFFFF;
    localparam int          MAXC      = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw  = 4'd0;
    logic [10:0] px  = 11'd0;
    logic [10:0] py  = 11'd0;
    logic        pv  = 1'b0;
    logic [17:0] ra1, ra3;
    logic [23:0] rd1 = 24'd0;
    logic [23:0] rd3 = 24'd0;
    logic [17:0] d3a = 18'd0;
    logic [17:0] d3b = 18'd0;
    logic [23:0] pd1, pd3;
    logic        pdv1, pdv3;

    always #5 clk = ~clk;

    // Image ROM models holding data = address.
    always @(posedge clk) begin
        rd1 <= {6'd0, ra1};
        d3a <= ra3;
        d3b <= d3a;
        rd3 <= {6'd0, d3b};
    end

    lcd_pic_overlay_pipe #(.ROM_LAT(1)) u_dut1 (
        .clk_in(clk), .sys_rst(rst), .sw(sw), .pix_x(px), .pix_y(py), .pix_valid(pv),
        .rom_addr(ra1), .rom_data(rd1), .pix_data(pd1), .pix_data_valid(pdv1)
    );

    lcd_pic_overlay_pipe #(.ROM_LAT(3)) u_dut3 (
        .clk_in(clk), .sys_rst(rst), .sw(sw), .pix_x(px), .pix_y(py), .pix_valid(pv),
        .rom_addr(ra3), .rom_data(rd3), .pix_data(pd3), .pix_data_valid(pdv3)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    int         n      = 0;
    logic [3:0] h_sw [0:MAXC-1];
    logic       h_pv [0:MAXC-1];
    int         h_x  [0:MAXC-1];
    int         h_y  [0:MAXC-1];
    int         fsc  [0:MAXC];
    int         le   [0:3][0:MAXC-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h, required %h", tag, obs, expv);
    endtask

    function automatic logic [3:0] sw_at(input int c);
        if (c < 0) return 4'd0;
        return h_sw[c];
    endfunction

    function automatic bit in_img(input int x, input int y);
        return (x >= 120) && (x < 680) && (y >= 80) && (y < 400);
    endfunction

    function automatic logic [31:0] exp_addr(input int t);
        if (!in_img(h_x[t], h_y[t])) return 32'd0;
        return 32'((h_y[t] - 80) * 560 + (h_x[t] - 120));
    endfunction

    function automatic logic [31:0] exp_valid(input int t);
        if (t < 0) return 32'd0;
        return h_pv[t] ? 32'd1 : 32'd0;
    endfunction

    // Colour of the pixel presented in cycle t, seen by an instance with ROM latency lat.
    // Flash/switch state is the state visible in cycle m, just before the output register loads.
    function automatic logic [31:0] exp_pix(input int t, input int lat);
        int x, y, m, idx, e;
        logic [3:0] s;
        if (t < 0) return 32'd0;
        if (!h_pv[t]) return 32'd0;
        x = h_x[t];
        y = h_y[t];
        m = t + lat + 1;
        if (y >= 300 && y < 400 && x >= 120 && x < 680) begin
            idx = (x - 120) / 140;
            e = le[idx][m-1];
            if (e >= 0 && (fsc[m] - fsc[e+1]) < 8) return {8'd0, COL_FLASH};
            s = sw_at(m - 2);
            return s[idx] ? {8'd0, COL_ON} : {8'd0, COL_OFF};
        end
        if (in_img(x, y)) return exp_addr(t);
        return {8'd0, COL_BG};
    endfunction

    task automatic record();
        logic [3:0] a, b;
        h_sw[n] = sw;
        h_pv[n] = pv;
        h_x[n]  = int'(px);
        h_y[n]  = int'(py);
        fsc[n+1] = fsc[n] + ((pv && px == 11'd0 && py == 11'd0) ? 1 : 0);
        a = sw_at(n - 2);
        b = sw_at(n - 3);
        for (int i = 0; i < 4; i++) begin
            le[i][n] = (a[i] != b[i]) ? n : ((n > 0) ? le[i][n-1] : -1);
        end
    endtask

    task automatic step();
        record();
        @(posedge clk);
        #1;
        n++;
        chk("pix_data_lat1",  32'(pd1),  exp_pix(n - 3, 1));
        chk("pix_valid_lat1", 32'(pdv1), exp_valid(n - 3));
        chk("pix_data_lat3",  32'(pd3),  exp_pix(n - 5, 3));
        chk("pix_valid_lat3", 32'(pdv3), exp_valid(n - 5));
        if (h_pv[n-1]) begin
            chk("rom_addr_lat1", 32'(ra1), exp_addr(n - 1));
            chk("rom_addr_lat3", 32'(ra3), exp_addr(n - 1));
        end
    endtask

    task automatic pix(input int x, input int y);
        px = 11'(x);
        py = 11'(y);
        pv = 1'b1;
        step();
    endtask

    task automatic idle();
        px = 11'($urandom_range(0, 2047));
        py = 11'($urandom_range(0, 2047));
        pv = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sw = 4'($urandom);
            px = 11'($urandom_range(0, 799));
            py = 11'($urandom_range(0, 479));
            pv = 1'b1;
            @(posedge clk);
            #1;
            chk("reset_pix_data",  32'(pd1) | 32'(pd3), 32'd0);
            chk("reset_pix_valid", 32'(pdv1) | 32'(pdv3), 32'd0);
            chk("reset_rom_addr",  32'(ra1) | 32'(ra3), 32'd0);
        end
        n      = 0;
        fsc[0] = 0;
        rst    = 1'b0;
    endtask

    // Button idx flashes for exactly 8 frame starts after its edge; button oidx keeps ocol.
    task automatic flash_run(input int idx, input logic [23:0] after, input int oidx, input logic [23:0] ocol);
        for (int j = 0; j <= 8; j++) begin
            pix(130 + 140 * idx, 350);
            pix(130 + 140 * oidx, 350);
            idle();
            chk("flash_button", 32'(pd1), (j < 8) ? {8'd0, COL_FLASH} : {8'd0, after});
            idle();
            chk("flash_other_button", 32'(pd1), {8'd0, ocol});
            if (j < 8) pix(0, 0);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        pix(200, 200);
        idle();
        chk("first_valid_early", 32'(pdv1), 32'd0);
        idle();
        chk("first_valid_at_L", 32'(pdv1), 32'd1);

        pix(120, 80);
        chk("addr_120_80", 32'(ra1), 32'd0);
        pix(679, 80);
        chk("addr_679_80", 32'(ra1), 32'd559);
        pix(120, 399);
        chk("addr_120_399", 32'(ra1), 32'd178640);
        pix(680, 80);
        chk("addr_680_80", 32'(ra1), 32'd0);
        idle();
        idle();
        chk("bg_680_80", 32'(pd1), {8'd0, COL_BG});

        sw = 4'b0101;
        repeat (4) idle();
        repeat (9) pix(0, 0);
        for (int b = 0; b < 4; b++) begin
            pix(130 + 140 * b, 350);
            idle();
            idle();
            chk("button_static", 32'(pd1), (b % 2 == 0) ? {8'd0, COL_ON} : {8'd0, COL_OFF});
        end
        pix(119, 350);
        idle();
        idle();
        chk("left_of_buttons", 32'(pd1), {8'd0, COL_BG});

        sw = 4'b0001;
        repeat (4) idle();
        repeat (9) pix(0, 0);
        sw = 4'b0101;
        repeat (3) idle();
        flash_run(2, COL_ON, 0, COL_ON);

        sw = 4'b0111;
        idle();
        idle();
        pix(0, 0);
        flash_run(1, COL_ON, 3, COL_OFF);

        sw = 4'b0101;
        repeat (3) idle();
        repeat (4) pix(0, 0);
        sw = 4'b0111;
        repeat (3) idle();
        flash_run(1, COL_ON, 3, COL_OFF);

        for (int i = 0; i < 20; i++) pix($urandom_range(0, 799), $urandom_range(0, 479));
        do_reset();

        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < 8; r++) begin
                int y;
                case (r)
                    0:       y = 0;
                    1:       y = 79 + f % 3;
                    2:       y = 299 + f % 3;
                    3:       y = 349;
                    4:       y = 398 + f % 3;
                    default: y = $urandom_range(0, 479);
                endcase
                for (int x = 0; x < 800; x++) begin
                    if ($urandom_range(0, 299) == 0) begin
                        int bsel;
                        bsel = $urandom_range(0, 3);
                        sw[bsel] = ~sw[bsel];
                    end
                    px = 11'(x);
                    py = 11'(y);
                    pv = ($urandom_range(0, 15) != 0);
                    step();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
